// File: rtl/sn_stream_decoder.sv
// sn_stream_decoder
//   Converts a serial stochastic-number bit stream back to a binary value by
//   counting ones over a window of N = 2^WIN_LOG2 accepted bits.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   sn_bit       stream bit
//   sn_valid     sn_bit is valid (only looked at while accumulating)
//   start        begin / restart a window
//   bipolar      0: unipolar P = ones/N, 1: bipolar V = (2*ones-N)/N
//   continuous   automatically start the next window after each result
//   result       decoded value (unsigned or two's complement)
//   result_valid one-cycle strobe when result updates
//   ones_count   raw ones count of the last completed window
//   busy         high while accumulating
module sn_stream_decoder #(
   parameter int unsigned WIN_LOG2 = 8,
   parameter int unsigned OUT_W    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sn_bit,
   input  logic                sn_valid,
   input  logic                start,
   input  logic                bipolar,
   input  logic                continuous,
   output logic [OUT_W-1:0]    result,
   output logic                result_valid,
   output logic [WIN_LOG2:0]   ones_count,
   output logic                busy
);

   localparam int unsigned DW    = ((WIN_LOG2 > OUT_W) ? WIN_LOG2 : OUT_W) + 2;
   // Scaling by 2^OUT_W / N (unipolar) or 2^(OUT_W-1) / N (bipolar) as a pure shift.
   localparam int unsigned U_SHL = (OUT_W > WIN_LOG2) ? OUT_W - WIN_LOG2 : 0;
   localparam int unsigned U_SHR = (WIN_LOG2 > OUT_W) ? WIN_LOG2 - OUT_W : 0;
   localparam int unsigned B_SHL = (OUT_W - 1 > WIN_LOG2) ? OUT_W - 1 - WIN_LOG2 : 0;
   localparam int unsigned B_SHR = (WIN_LOG2 > OUT_W - 1) ? WIN_LOG2 - (OUT_W - 1) : 0;

   localparam logic [DW-1:0] N_EXT = {{(DW-1){1'b0}}, 1'b1} << WIN_LOG2;
   localparam logic [DW-1:0] U_MAX = {{(DW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
   localparam logic [DW-1:0] S_MAX = {{(DW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

   typedef enum logic [0:0] {StIdle, StAccum} state_e;

   state_e                state_q, state_d;
   logic [WIN_LOG2-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIN_LOG2:0]     ones_acc_q, ones_acc_d;
   logic [OUT_W-1:0]      result_q, result_d;
   logic [WIN_LOG2:0]     ones_count_q, ones_count_d;
   logic                  result_valid_q, result_valid_d;

   logic [WIN_LOG2:0]     ones_final;
   logic [DW-1:0]         ones_ext;
   logic [DW-1:0]         u_val;
   logic signed [DW-1:0]  b_diff;
   logic signed [DW-1:0]  b_val;
   logic [OUT_W-1:0]      decoded;
   logic                  last_bit;

   // Count including the bit being accepted on this edge.
   assign ones_final = ones_acc_q + {{WIN_LOG2{1'b0}}, sn_bit};
   assign ones_ext   = {{(DW-WIN_LOG2-1){1'b0}}, ones_final};
   assign u_val      = (ones_ext << U_SHL) >> U_SHR;
   assign b_diff     = $signed((ones_ext << 1) - N_EXT);
   // Arithmetic right shift floors toward -inf.
   assign b_val      = (b_diff <<< B_SHL) >>> B_SHR;
   assign last_bit   = (bit_cnt_q == {WIN_LOG2{1'b1}});

   always_comb begin
      decoded = '0;
      if (bipolar) begin
         // Only ones_final = N can exceed the positive limit; the low end is exact.
         decoded = (b_val > $signed(S_MAX)) ? S_MAX[OUT_W-1:0] : b_val[OUT_W-1:0];
      end else begin
         decoded = (u_val > U_MAX) ? U_MAX[OUT_W-1:0] : u_val[OUT_W-1:0];
      end
   end

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      ones_acc_d     = ones_acc_q;
      result_d       = result_q;
      ones_count_d   = ones_count_q;
      result_valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StAccum;
               bit_cnt_d  = '0;
               ones_acc_d = '0;
            end
         end
         StAccum: begin
            if (start) begin
               // Restart wins over completion; a coincident bit is dropped.
               bit_cnt_d  = '0;
               ones_acc_d = '0;
            end else if (sn_valid) begin
               if (last_bit) begin
                  ones_count_d   = ones_final;
                  result_d       = decoded;
                  result_valid_d = 1'b1;
                  bit_cnt_d      = '0;
                  ones_acc_d     = '0;
                  state_d        = continuous ? StAccum : StIdle;
               end else begin
                  bit_cnt_d  = bit_cnt_q + 1'b1;
                  ones_acc_d = ones_final;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         bit_cnt_q      <= '0;
         ones_acc_q     <= '0;
         result_q       <= '0;
         ones_count_q   <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         ones_acc_q     <= ones_acc_d;
         result_q       <= result_d;
         ones_count_q   <= ones_count_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign ones_count   = ones_count_q;
   assign busy         = (state_q == StAccum);

endmodule
